layer_mem_arbiter: RTL and testbench
====================================

# layer_mem_arbiter

Shares the single layer-memory port (csel / caddr / cdata, cwr / crd) of the CNN accelerator between several internal requesters: the convolution writer, the max-pool read-modify-write engine and the flatten unit. It performs round-robin arbitration with optional bounded locking for bursts. It issues exactly one memory transaction per cycle and returns read data tagged to the originating requester. It sits between the layer engines and the external layer memory, replacing direct drive of cwr/crd/csel.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 12, memory address width
- DATA_W, 20, memory data width
- SEL_W, 3, layer-select width (csel)
- LOCK_MAX, 16, maximum consecutive accepted transactions under lock before forced release
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester transaction request
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep ownership after this transaction
- req_sel  in  NUM_REQ*SEL_W  layer select, requester i at [i*SEL_W +: SEL_W]
- req_addr  in  NUM_REQ*ADDR_W  address, packed likewise
- req_wdata  in  NUM_REQ*DATA_W  write data, packed likewise
- req_ready  out  NUM_REQ  one-hot accept; a handshake occurs when valid & ready
- rsp_valid  out  NUM_REQ  one-hot read-data-valid pulse
- rsp_data  out  DATA_W  read data, shared by all requesters
- cwr  out  1  memory write strobe
- crd  out  1  memory read strobe
- csel  out  SEL_W  memory layer select
- caddr_wr / caddr_rd  out  ADDR_W  write / read address
- cdata_wr  out  DATA_W  write data
- cdata_rd  in  DATA_W  read data; valid in the cycle after crd is high

## Operation
- Eligibility: if an owner is locked, only the owner is eligible. Otherwise all requesters with req_valid are eligible.
- Winner: the first eligible requester at or after rr_ptr, scanning upward with wrap. req_ready is combinational and asserted only for the winner, in the same cycle.
- rr_ptr (reset 0): on an unlocked accept, it becomes winner+1 mod NUM_REQ. It is unchanged while locked.
- Lock: an accept with req_lock=1 sets owner=winner and increments lock_cnt. An accept with req_lock=0 clears the owner and sets lock_cnt to 0.
- Forced release: an accept with req_lock=1 that brings lock_cnt to LOCK_MAX releases the owner anyway. rr_ptr then advances past that owner.
- A locked owner that drops req_valid keeps the lock; nobody is granted until the owner requests again or the lock is released.
- Issue register: on an accept, the next cycle drives one of two strobes, never both:
  - cwr=req_wr, driving csel, caddr_wr and cdata_wr;
  - crd=~req_wr, driving csel and caddr_rd.
- With no accept, the next cycle has cwr=crd=0, and csel, the addresses and cdata_wr hold their last values.
- Read return: a 2-stage tag pipe carries the requester id. cdata_rd is registered into rsp_data, and rsp_valid[id] pulses for 1 cycle.
- Back-to-back reads from different requesters return in issue order, one per cycle.
- Reset values: req_ready=0 (combinational, gated by reset), and all of rsp_valid, rsp_data, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr are 0. The owner is cleared and rr_ptr=0.
- Reset mid-operation: in-flight reads are discarded with no rsp_valid, and arbitration restarts from requester 0.

## Timing
- Throughput: 1 transaction per cycle sustained.
- Latency, for an accept at cycle T:
  - cwr/crd high in T+1;
  - cdata_rd sampled at the end of T+2;
  - rsp_valid high in T+3.
- A new lock owner wins at T and is the sole eligible requester from T+1.
- Zero dead cycles between owners.
- Simultaneous events:
  - a release accept and other valid requests in the same cycle: the new arbitration applies from T+1;
  - a read response and a new accept in the same cycle are independent.

## Structure
- Shared package layer_mem_pkg: SEL_W/ADDR_W/DATA_W constants and csel encodings, with 0 = none and 1..5 = the five layer memories.
- Sub-module rr_picker: combinational, taking eligible[NUM_REQ] and ptr and producing a one-hot grant. It is also reused by other engines.
- Top level holds the lock/owner registers, the issue register and the response tag pipe.

## Test plan
- Single write: req 0 writes sel=1, addr=0x041, data=0x01310 -> ready0 at T; cwr=1, caddr_wr=0x041, cdata_wr=0x01310, crd=0 at T+1.
- Single read: req 2 reads sel=3, addr=0x3FF while the memory model returns 0x0ABCD -> crd=1 at T+1; rsp_valid=3'b100, rsp_data=0x0ABCD at T+3.
- Contention: all 3 valid, unlocked, continuously -> grant order 0,1,2,0,1,2; no cycle with cwr&crd.
- Lock burst: req 1 valid+locked for 4 beats while req 0 and req 2 stay valid -> 1,1,1,1 then 2,0.
- Lock timeout: req 0 holds lock continuously, req 1 valid -> exactly 16 grants to 0, then req 1 granted.
- Reset mid-read: assert reset_n=0 at T+1 after a read accept -> all outputs 0 immediately, no rsp_valid; after release, req 0 is granted first.

Source files
------------

// File: rtl/layer_mem_pkg.sv
// Shared constants for the layer-memory port: bus widths and csel encodings.
// 0 selects no memory; 1..5 select the five layer memories.
package layer_mem_pkg;

    localparam int LM_SEL_W  = 3;
    localparam int LM_ADDR_W = 12;
    localparam int LM_DATA_W = 20;

    typedef enum logic [LM_SEL_W-1:0] {
        CSEL_NONE = 3'd0,
        CSEL_L1   = 3'd1,
        CSEL_L2   = 3'd2,
        CSEL_L3   = 3'd3,
        CSEL_L4   = 3'd4,
        CSEL_L5   = 3'd5
    } csel_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first eligible
// requester at or after ptr, scanning upward with wrap-around.
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int               idx;
    logic [PTR_W-1:0] idx_v;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_v = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            idx_v = PTR_W'(idx);
            if (!found && eligible[idx_v]) begin
                grant[idx_v] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter with bounded burst locking for the single layer-memory
// port; issues one transaction per cycle and returns tagged read data.
module layer_mem_arbiter
    import layer_mem_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = LM_ADDR_W,
    parameter int DATA_W   = LM_DATA_W,
    parameter int SEL_W    = LM_SEL_W,
    parameter int LOCK_MAX = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [NUM_REQ-1:0]      req_lock,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    cwr,
    output logic                    crd,
    output logic [SEL_W-1:0]        csel,
    output logic [ADDR_W-1:0]       caddr_wr,
    output logic [ADDR_W-1:0]       caddr_rd,
    output logic [DATA_W-1:0]       cdata_wr,
    input  logic [DATA_W-1:0]       cdata_rd
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic               locked;
    logic [ID_W-1:0]    owner;
    logic [CNT_W-1:0]   lock_cnt;
    logic [ID_W-1:0]    rr_ptr;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    win_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               w_wr, w_lock;
    logic [SEL_W-1:0]   w_sel;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;

    logic               t1_v, t2_v;
    logic [ID_W-1:0]    t1_id, t2_id;

    // Handshake: requester i holds its fields stable while req_valid[i] is high;
    // the transaction is taken in the cycle where req_valid[i] & req_ready[i].
    always_comb begin
        eligible = locked ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;
    end

    rr_picker #(.N(NUM_REQ), .PTR_W(ID_W)) u_picker (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant)
    );

    assign req_ready = reset_n ? grant : '0;
    assign accept    = reset_n & (|grant);

    always_comb begin
        win    = '0;
        w_wr   = 1'b0;
        w_lock = 1'b0;
        w_sel  = '0;
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win    = ID_W'(i);
                w_wr   = req_wr[i];
                w_lock = req_lock[i];
                w_sel  = req_sel[i*SEL_W +: SEL_W];
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_data = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        win_inc = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        cnt_inc = lock_cnt + 1'b1;
    end

    // rr_ptr only moves on accepts that leave the port unlocked, including
    // the forced release when a burst hits LOCK_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            owner    <= '0;
            lock_cnt <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            if (w_lock && (cnt_inc != CNT_W'(LOCK_MAX))) begin
                locked   <= 1'b1;
                owner    <= win;
                lock_cnt <= cnt_inc;
            end else begin
                locked   <= 1'b0;
                lock_cnt <= '0;
                rr_ptr   <= win_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= CSEL_NONE;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
        end else begin
            cwr <= accept & w_wr;
            crd <= accept & ~w_wr;
            if (accept) begin
                csel <= w_sel;
                if (w_wr) begin
                    caddr_wr <= w_addr;
                    cdata_wr <= w_data;
                end else begin
                    caddr_rd <= w_addr;
                end
            end
        end
    end

    // Tag pipe: stage 1 aligns with crd, stage 2 with cdata_rd.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t1_v      <= 1'b0;
            t1_id     <= '0;
            t2_v      <= 1'b0;
            t2_id     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            t1_v      <= accept & ~w_wr;
            t1_id     <= win;
            t2_v      <= t1_v;
            t2_id     <= t1_id;
            rsp_valid <= t2_v ? (NUM_REQ'(1) << t2_id) : '0;
            if (t2_v) rsp_data <= cdata_rd;
        end
    end

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter: hand-computed grants, strobes and
// tagged read returns against a simple memory model.
module tb_layer_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 20;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_wr, req_lock;
    logic [N*SW-1:0] req_sel;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            cwr, crd;
    logic [SW-1:0]   csel;
    logic [AW-1:0]   caddr_wr, caddr_rd;
    logic [DW-1:0]   cdata_wr;
    logic [DW-1:0]   cdata_rd = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N+DW-1:0] exp_q[$];
    logic [N+DW-1:0] mon_e;

    // clock / reset
    always #5 clk = ~clk;

    layer_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_lock(req_lock),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .cwr(cwr), .crd(crd), .csel(csel),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
    );

    function automatic logic [DW-1:0] rd_model(input logic [SW-1:0] s, input logic [AW-1:0] a);
        if (a == 12'h3FF) return 20'h0ABCD;
        return {s, 5'h00, a};
    endfunction

    // memory model: data valid the cycle after crd
    always @(posedge clk) cdata_rd <= crd ? rd_model(csel, caddr_rd) : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard on returned reads
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_rsp_id", 32'(rsp_valid), 32'(mon_e[DW +: N]));
                check("sb_rsp_data", 32'(rsp_data), 32'(mon_e[DW-1:0]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req_valid = '0; req_wr = '0; req_lock = '0;
        req_sel = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic wr, input logic lk,
                           input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_wr[i]    = wr;
        req_lock[i]  = lk;
        req_sel[i*SW +: SW]   = s;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_g;

        reset_n = 1'b0;
        clear_all();
        req_valid = 3'b111;
        repeat (3) tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_cwr", 32'(cwr), 32'h0);
        check("rst_crd", 32'(crd), 32'h0);
        check("rst_csel", 32'(csel), 32'h0);
        check("rst_caddr_wr", 32'(caddr_wr), 32'h0);
        check("rst_caddr_rd", 32'(caddr_rd), 32'h0);
        check("rst_cdata_wr", 32'(cdata_wr), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        clear_all();
        reset_n = 1'b1;
        tick();

        // single write from req 0
        set_req(0, 1, 1, 0, 3'd1, 12'h041, 20'h01310);
        #1 check("wr_ready", 32'(req_ready), 32'h1);
        tick(); clear_all();
        check("wr_cwr", 32'(cwr), 32'h1);
        check("wr_crd", 32'(crd), 32'h0);
        check("wr_csel", 32'(csel), 32'h1);
        check("wr_caddr", 32'(caddr_wr), 32'h041);
        check("wr_cdata", 32'(cdata_wr), 32'h01310);
        tick();
        check("idle_cwr", 32'(cwr), 32'h0);
        check("idle_csel_hold", 32'(csel), 32'h1);
        check("idle_cdata_hold", 32'(cdata_wr), 32'h01310);

        // single read from req 2 (rr_ptr is now 1)
        set_req(2, 1, 0, 0, 3'd3, 12'h3FF, 20'h0);
        exp_q.push_back({3'b100, 20'h0ABCD});
        #1 check("rd_ready", 32'(req_ready), 32'h4);
        tick(); clear_all();
        check("rd_crd", 32'(crd), 32'h1);
        check("rd_cwr", 32'(cwr), 32'h0);
        check("rd_caddr", 32'(caddr_rd), 32'h3FF);
        check("rd_csel", 32'(csel), 32'h3);
        tick();
        check("rd_crd_off", 32'(crd), 32'h0);
        tick();
        check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
        check("rd_rsp_data", 32'(rsp_data), 32'h0ABCD);
        tick();
        check("rd_rsp_pulse", 32'(rsp_valid), 32'h0);

        // contention: all three writing, unlocked (rr_ptr is now 0)
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 0, 3'd2, 12'(16 * i), 20'(i));
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            #1 check("cont_grant", 32'(req_ready), 32'(exp_g));
            tick();
            check("cont_one_strobe", 32'(cwr & crd), 32'h0);
            check("cont_cwr", 32'(cwr), 32'h1);
        end
        clear_all();

        // move rr_ptr to 1
        set_req(0, 1, 1, 0, 3'd1, 12'h001, 20'h00001);
        #1 check("pre_lock_grant", 32'(req_ready), 32'h1);
        tick(); clear_all();

        // lock burst by req 1 while req 0 and req 2 keep requesting
        set_req(0, 1, 1, 0, 3'd1, 12'h010, 20'h0);
        set_req(2, 1, 1, 0, 3'd1, 12'h030, 20'h0);
        set_req(1, 1, 1, 1, 3'd1, 12'h020, 20'h0);
        #1 check("lock_b1", 32'(req_ready), 32'h2);
        tick();
        #1 check("lock_b2", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        #1 check("lock_owner_idle", 32'(req_ready), 32'h0);
        tick();
        req_valid[1] = 1'b1;
        #1 check("lock_b3", 32'(req_ready), 32'h2);
        tick();
        req_lock[1] = 1'b0;
        #1 check("lock_b4_release", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        #1 check("after_lock_r2", 32'(req_ready), 32'h4);
        tick();
        #1 check("after_lock_r0", 32'(req_ready), 32'h1);
        tick(); clear_all();

        // reset in the cycle after a read accept
        set_req(0, 1, 0, 0, 3'd2, 12'h123, 20'h0);
        #1 check("mid_rd_ready", 32'(req_ready), 32'h1);
        tick();
        check("mid_rd_crd", 32'(crd), 32'h1);
        req_valid = 3'b111;
        reset_n = 1'b0;
        #1;
        check("mid_rst_crd", 32'(crd), 32'h0);
        check("mid_rst_csel", 32'(csel), 32'h0);
        check("mid_rst_caddr_rd", 32'(caddr_rd), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        clear_all();
        reset_n = 1'b1;
        tick();
        check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);

        // lock timeout: req 0 holds lock, req 1 waits; req 0 wins first after reset
        set_req(0, 1, 1, 1, 3'd1, 12'h100, 20'h00100);
        set_req(1, 1, 1, 0, 3'd1, 12'h200, 20'h00200);
        for (int k = 0; k < 16; k++) begin
            #1 check("timeout_hold", 32'(req_ready), 32'h1);
            tick();
        end
        #1 check("timeout_release", 32'(req_ready), 32'h2);
        tick(); clear_all();

        // back-to-back reads from req 0 then req 1 (rr_ptr is now 2)
        set_req(0, 1, 0, 0, 3'd2, 12'h010, 20'h0);
        set_req(1, 1, 0, 0, 3'd4, 12'h020, 20'h0);
        exp_q.push_back({3'b001, 20'h40010});
        exp_q.push_back({3'b010, 20'h80020});
        #1 check("b2b_first", 32'(req_ready), 32'h1);
        tick();
        #1 check("b2b_second", 32'(req_ready), 32'h2);
        tick(); clear_all();
        check("b2b_crd", 32'(crd), 32'h1);
        check("b2b_caddr_rd", 32'(caddr_rd), 32'h020);
        tick();
        check("b2b_rsp0_valid", 32'(rsp_valid), 32'h1);
        check("b2b_rsp0_data", 32'(rsp_data), 32'h40010);
        tick();
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'h2);
        check("b2b_rsp1_data", 32'(rsp_data), 32'h80020);
        tick();
        check("b2b_rsp_done", 32'(rsp_valid), 32'h0);
        repeat (2) tick();

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
